// File: rtl/md_engine.sv
// -----------------------------------------------------------------------------
// md_engine : multiply/divide engine for the E stage, owner of HI/LO.
//
// Runs signed/unsigned multiply and divide (plus multiply-accumulate and
// multiply-subtract when enabled) with a fixed, programmable latency, and
// reports busy/done, divide-by-zero, and supports cancel for exception flush.
//
// Configuration macro:
//   MD_ACC_EN  defined   : ops 100..111 (MADDU/MADD/MSUBU/MSUB) are legal and
//                          run with MUL_CYCLES latency.
//              undefined : ops with op[2]=1 are illegal and a start with such an
//                          op is ignored; the accumulator add/sub is not built.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high; clears all state
//   start      in   1      launch op with a/b (1-cycle pulse)
//   op         in   3      000 MULTU 001 MULT 010 DIVU 011 DIV
//                          100 MADDU 101 MADD 110 MSUBU 111 MSUB
//   a          in   WIDTH  operand rs (also the data for direct writes)
//   b          in   WIDTH  operand rt
//   we         in   1      direct write of a into HI or LO (mthi/mtlo)
//   write_sel  in   1      1: write HI, 0: write LO
//   cancel     in   1      abort in-flight op
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
//   busy       out  1      op in flight
//   done       out  1      1-cycle pulse on the cycle HI/LO commit
//   div_zero   out  1      1-cycle pulse with done when the divisor was 0
// -----------------------------------------------------------------------------
module md_engine #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic             write_sel,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_MUL  = CW'(MUL_CYCLES);
  localparam logic [CW-1:0]    CNT_DIV  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] pend_hi_q;
  logic [WIDTH-1:0] pend_lo_q;
  logic             pend_dz_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic               is_signed_s;
  logic               is_div_s;
  logic               op_legal_s;
  logic               launch_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   b_div_s;
  logic [WIDTH-1:0]   q_mag_s;
  logic [WIDTH-1:0]   r_mag_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [2*WIDTH-1:0] res_d;
  logic               dz_d;
  logic [CW-1:0]      lat_d;

  // Operation decode, legality and launch qualification.
  always_comb begin
    is_signed_s = op[0];
    is_div_s    = (op[2:1] == 2'b01);
`ifdef MD_ACC_EN
    op_legal_s  = 1'b1;
`else
    op_legal_s  = ~op[2];
`endif
    launch_s    = start & ~cancel & op_legal_s;
  end

  // Datapath: full-width product and sign-magnitude division.
  always_comb begin
    // Sign-extending to 2*WIDTH makes one unsigned multiplier serve both signednesses.
    ext_a_s = is_signed_s ? {{WIDTH{a[WIDTH-1]}}, a} : {W_ZERO, a};
    ext_b_s = is_signed_s ? {{WIDTH{b[WIDTH-1]}}, b} : {W_ZERO, b};
    prod_s  = ext_a_s * ext_b_s;

    // Divide on magnitudes; |MIN| fits as an unsigned value, so MIN/-1 yields MIN, rem 0.
    a_neg_s = is_signed_s & a[WIDTH-1];
    b_neg_s = is_signed_s & b[WIDTH-1];
    a_mag_s = a_neg_s ? (W_ZERO - a) : a;
    b_mag_s = b_neg_s ? (W_ZERO - b) : b;
    // A zero divisor is replaced so the divider never sees 0; that result is discarded.
    b_div_s = (b == W_ZERO) ? W_ONE : b_mag_s;
    q_mag_s = a_mag_s / b_div_s;
    r_mag_s = a_mag_s % b_div_s;
    quot_s  = (a_neg_s ^ b_neg_s) ? (W_ZERO - q_mag_s) : q_mag_s;
    rem_s   = a_neg_s ? (W_ZERO - r_mag_s) : r_mag_s;

    dz_d    = is_div_s & (b == W_ZERO);
    lat_d   = is_div_s ? CNT_DIV : CNT_MUL;

    case (op[2:1])
      2'b00:   res_d = prod_s;
      2'b01:   res_d = {rem_s, quot_s};
`ifdef MD_ACC_EN
      // Accumulate against HI/LO as they stand at launch.
      2'b10:   res_d = {hi_q, lo_q} + prod_s;
      2'b11:   res_d = {hi_q, lo_q} - prod_s;
`endif
      default: res_d = prod_s;
    endcase
  end

  // Control FSM: owns HI/LO, the pending result, the countdown and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      hi_q      <= W_ZERO;
      lo_q      <= W_ZERO;
      pend_hi_q <= W_ZERO;
      pend_lo_q <= W_ZERO;
      pend_dz_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (launch_s) begin
            pend_hi_q <= res_d[2*WIDTH-1:WIDTH];
            pend_lo_q <= res_d[WIDTH-1:0];
            pend_dz_q <= dz_d;
            cnt_q     <= lat_d;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end else if (we && !start) begin
            // Any start in the same cycle drops the direct write.
            if (write_sel) begin
              hi_q <= a;
            end else begin
              lo_q <= a;
            end
          end
        end
        S_RUN: begin
          if (cancel) begin
            // Flush: abandon the pending result without touching HI/LO.
            pend_hi_q <= W_ZERO;
            pend_lo_q <= W_ZERO;
            pend_dz_q <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else if (cnt_q == CNT_ONE) begin
            // Divide-by-zero completes with done but leaves HI/LO untouched.
            if (!pend_dz_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            done_q  <= 1'b1;
            dz_q    <= pend_dz_q;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= {CW{1'b0}};
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_md_engine.sv
// -----------------------------------------------------------------------------
// tb_md_engine : self-checking bench for md_engine (WIDTH=32, 5/10 cycles).
// Expected HI/LO come from a reference model using 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_md_engine;

  localparam int W    = 32;
  localparam int NMUL = 5;
  localparam int NDIV = 10;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         we = 1'b0;
  logic         write_sel = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  md_engine #(.WIDTH(W), .MUL_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .we(we), .write_sel(write_sel), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected HI/LO, div-by-zero flag and busy length (0 = not launched).
  task automatic ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] eh, output logic [W-1:0] el,
                        output logic edz, output int n);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0]     p, acc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = x;
    uy = y;
    p  = o[0] ? 64'(sx * sy) : 64'(ux * uy);
    acc = {m_hi, m_lo};
    eh = m_hi; el = m_lo; edz = 1'b0; n = NMUL;
    case (o[2:1])
      2'b00: begin eh = p[63:32]; el = p[31:0]; end
      2'b01: begin
        n = NDIV;
        if (y == 32'd0) edz = 1'b1;
        else if (o[0]) begin
          q = sx / sy; r = sx % sy;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = 32'(ux / uy); eh = 32'(ux % uy);
        end
      end
      default: begin
`ifdef MD_ACC_EN
        acc = (o[1] == 1'b0) ? acc + p : acc - p;
        eh = acc[63:32]; el = acc[31:0];
`else
        n = 0;
`endif
      end
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int cancel_at, input bit poke);
    logic [W-1:0] eh, el;
    logic edz;
    int n, cyc, exp_cyc;
    bit commit;
    ref_op(o, x, y, eh, el, edz, n);
    commit  = (n > 0) && !((cancel_at > 0) && (cancel_at <= n));
    exp_cyc = commit ? n : ((n == 0) ? 0 : cancel_at);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      chk("done_while_busy", {63'd0, done}, 64'd0);
      chk("hi_while_busy", {32'd0, hi}, {32'd0, m_hi});
      chk("lo_while_busy", {32'd0, lo}, {32'd0, m_lo});
      start = 1'b0; we = 1'b0; cancel = 1'b0;
      if (cyc == cancel_at) cancel = 1'b1;
      if (poke && cyc == 1) begin
        start = 1'b1; op = OP_MULTU; a = 32'hDEAD_BEEF; b = 32'd2; we = 1'b1; write_sel = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0; we = 1'b0; cancel = 1'b0;
    chk("busy_cycles", 64'(cyc), 64'(exp_cyc));
    chk("done_pulse", {63'd0, done}, {63'd0, commit});
    chk("div_zero", {63'd0, div_zero}, {63'd0, commit & edz});
    if (commit && !edz) begin m_hi = eh; m_lo = el; end
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
    @(negedge clk);
    chk("done_clear", {63'd0, done}, 64'd0);
    chk("div_zero_clear", {63'd0, div_zero}, 64'd0);
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic wr(input bit sel, input logic [W-1:0] v);
    @(negedge clk); we = 1'b1; write_sel = sel; a = v;
    @(negedge clk); we = 1'b0;
    if (sel) m_hi = v; else m_lo = v;
    chk("wr_busy", {63'd0, busy}, 64'd0);
    chk("wr_done", {63'd0, done}, 64'd0);
    chk("wr_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("wr_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    logic [2:0] ro;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    reset = 1'b0;

    // Directed arithmetic
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    chk("mult_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
    chk("divu_lo_const", {32'd0, lo}, 64'd14);
    chk("divu_hi_const", {32'd0, hi}, 64'd2);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    chk("div_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    chk("div_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);

    // Divide by zero leaves HI/LO
    wr(1'b1, 32'h11);
    wr(1'b0, 32'h22);
    run_op(OP_DIV, 32'd5, 32'd0, 0, 1'b0);
    chk("dz_hi_const", {32'd0, hi}, 64'h11);
    chk("dz_lo_const", {32'd0, lo}, 64'h22);

    // Cancel on 3rd busy cycle, cancel on the commit cycle, start/we while busy
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 3, 1'b0);
    run_op(OP_DIVU, 32'd1000, 32'd9, NDIV, 1'b0);
    run_op(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, 0, 1'b1);

    // Cancel and start together: nothing launched
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("cancel_start_done", {63'd0, done}, 64'd0);
    chk("cancel_start_lo", {32'd0, lo}, {32'd0, m_lo});

    // Accumulate (illegal when the accumulator is not built)
    wr(1'b0, 32'd5);
    wr(1'b1, 32'd0);
    run_op(OP_MADD, 32'd2, 32'd3, 0, 1'b0);
`ifdef MD_ACC_EN
    chk("madd_lo_const", {32'd0, lo}, 64'd11);
`else
    chk("madd_lo_const", {32'd0, lo}, 64'd5);
`endif
    run_op(OP_MSUB, 32'hFFFF_FFF0, 32'd3, 0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
      run_op(ro, ra, rb, 0, 1'b0);
    end

    // Asynchronous reset mid-divide
    wr(1'b1, 32'h55);
    @(negedge clk); start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_hi", {32'd0, hi}, 64'd0);
    chk("async_lo", {32'd0, lo}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    m_hi = '0; m_lo = '0;
    #1 reset = 1'b0;
    run_op(OP_DIVU, 32'd9, 32'd3, 0, 1'b0);
    chk("post_rst_lo_const", {32'd0, lo}, 64'd3);
    chk("post_rst_hi_const", {32'd0, hi}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
